alu_req_scheduler: RTL and testbench
====================================

Name: alu_req_scheduler

Overview:
Shares one combinational 8-bit ALU (4-bit op select, 16-bit result, zero/negative/carry/overflow/parity flags) between two requesters. Arbitrates round-robin, holds the granted operands stable on the ALU inputs for a configurable settle window, and registers the result and flags. It returns them on a valid/ready response channel tagged with the requester id. Divide and modulo by zero, and unused op codes, are trapped before reaching the ALU.

Parameters:
EXEC_CYCLES, 1, cycles the ALU inputs are held before the result is captured (1..15; >1 allows a multicycle path for multiply/divide)
NUM_OPS, 13, op codes 0..NUM_OPS-1 are legal; all others are trapped

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_A  in  8  operand A
req0_B  in  8  operand B
req0_S  in  4  op select
req1_valid, req1_ready, req1_A, req1_B, req1_S  same as requester 0
alu_A  out  8  to ALU operand A
alu_B  out  8  to ALU operand B
alu_S  out  4  to ALU op select
alu_o  in  16  ALU result
alu_zero, alu_negative, alu_carry, alu_overflow, alu_parity  in  1 each  ALU flags
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that issued the operation
rsp_o  out  16  registered result
rsp_flags  out  5  {zero,negative,carry,overflow,parity}, registered
rsp_err  out  1  1 = trapped operation (div/mod by zero or illegal op)

Behaviour:
- Clocking and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, rr_last=1 (requester 0 wins first tie), rsp_valid=0, rsp_o=0, rsp_flags=0, rsp_err=0, rsp_id=0, alu_A/B/S=0, req*_ready=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqX_ready = (state==IDLE) && grantX, combinationally.
  - Grant rule: if only one requester is valid, grant it. If both are valid, grant the one != rr_last.
  - On a handshake: latch A/B/S into operand registers, set rr_last = granted id, latch id.
  - Trap check at accept: (S==4'b0110 || S==4'b1001) && B==0, or S >= NUM_OPS.
  - Trapped: go to RESP with rsp_o=0, rsp_flags=0, rsp_err=1. The ALU inputs are not updated.
  - Otherwise: go to EXEC with counter=0.
- EXEC:
  - alu_A/B/S are driven from the operand registers and stay stable throughout.
  - Counter increments each cycle.
  - When counter==EXEC_CYCLES-1: capture alu_o into rsp_o and the flags into rsp_flags, set rsp_err=0, go to RESP.
- RESP:
  - rsp_valid=1. rsp_* stay stable until rsp_ready.
  - On rsp_valid && rsp_ready: return to IDLE and deassert rsp_valid the next cycle.
  - No new request is accepted while in RESP; there is no bypass.
- Latency: accept at cycle N, rsp_valid at N+1+EXEC_CYCLES. A trapped op responds at N+1.
- Throughput: at most one op per 2+EXEC_CYCLES cycles when rsp_ready is held high.
- Requester inputs may change while not ready; only values at the handshake matter.
- A requester dropping valid before being granted is legal and causes no grant.
- Reset mid-operation (any state): the in-flight op is discarded, no response is produced, and all outputs return to reset values next cycle.
- Back-to-back: if the same requester is the only one valid, it is granted again.

Decomposition:
- Shared package: state enum (IDLE/EXEC/RESP), the ALU op code constants (ADD 0, SUB 1, MUL 2, AND 3, OR 4, XOR 5, MOD 6, SHL 7, SHR 8, DIV 9, EQ 10, LT 11, GT 12), and the flag bit index constants.
- One natural sub-module: rr_arbiter2 (2-input round-robin, inputs valid0/valid1/last, outputs grant0/grant1).

Test Plan:
- Reset, then req0 A=200 B=100 S=0 -> rsp at N+2 (EXEC_CYCLES=1): rsp_o=0x012C, carry=1, zero=0, rsp_id=0, rsp_err=0.
- req0 and req1 valid in the same cycle, three rounds -> grant order 0,1,0. Each rsp_id matches, and no request is dropped or duplicated.
- req1 A=7 B=0 S=9 -> rsp one cycle after accept: rsp_err=1, rsp_o=0, rsp_flags=0, and alu_S unchanged. Repeat with S=6 and B=0, and with S=13 -> same result.
- Hold rsp_ready=0 for 5 cycles with req0 A=12 B=12 S=10 -> rsp_o=1 stable throughout, req0_ready/req1_ready stay 0, completes on rsp_ready.
- EXEC_CYCLES=3, A=255 B=255 S=2 -> alu_A/B/S stable for 3 cycles, rsp_o=0xFE01 at N+4.
- Assert rst in EXEC -> rsp_valid never rises, state=IDLE, and the next request is handled normally with requester 0 winning a tie.

Source files
------------

// File: rtl/alu_req_scheduler_pkg.sv
// Shared types and constants for the two-requester ALU scheduler:
// FSM states, ALU op codes, response flag bit positions and the trap rule.
package alu_req_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_RESP
   } state_t;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_OR  = 4'd4;
   localparam logic [3:0] OP_XOR = 4'd5;
   localparam logic [3:0] OP_MOD = 4'd6;
   localparam logic [3:0] OP_SHL = 4'd7;
   localparam logic [3:0] OP_SHR = 4'd8;
   localparam logic [3:0] OP_DIV = 4'd9;
   localparam logic [3:0] OP_EQ  = 4'd10;
   localparam logic [3:0] OP_LT  = 4'd11;
   localparam logic [3:0] OP_GT  = 4'd12;

   // rsp_flags = {zero, negative, carry, overflow, parity}
   localparam int FLAG_ZERO   = 4;
   localparam int FLAG_NEG    = 3;
   localparam int FLAG_CARRY  = 2;
   localparam int FLAG_OVF    = 1;
   localparam int FLAG_PARITY = 0;

   // Division/modulo by zero and op codes beyond the legal range never reach the ALU.
   function automatic logic is_trap(input logic [7:0] b, input logic [3:0] s, input int num_ops);
      return ((s == OP_MOD || s == OP_DIV) && b == 8'd0) || (int'(s) >= num_ops);
   endfunction

endpackage

// File: rtl/alu_req_scheduler_if.sv
// Request, ALU and response signals of the scheduler; the scheduler is the slave,
// the requesters/ALU/consumer environment is the master.
interface alu_req_scheduler_if;

   logic        req0_valid;
   logic        req0_ready;
   logic [7:0]  req0_A;
   logic [7:0]  req0_B;
   logic [3:0]  req0_S;

   logic        req1_valid;
   logic        req1_ready;
   logic [7:0]  req1_A;
   logic [7:0]  req1_B;
   logic [3:0]  req1_S;

   logic [7:0]  alu_A;
   logic [7:0]  alu_B;
   logic [3:0]  alu_S;
   logic [15:0] alu_o;
   logic        alu_zero;
   logic        alu_negative;
   logic        alu_carry;
   logic        alu_overflow;
   logic        alu_parity;

   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [15:0] rsp_o;
   logic [4:0]  rsp_flags;
   logic        rsp_err;

   modport slave (
      input  req0_valid, req0_A, req0_B, req0_S,
      input  req1_valid, req1_A, req1_B, req1_S,
      input  alu_o, alu_zero, alu_negative, alu_carry, alu_overflow, alu_parity,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output alu_A, alu_B, alu_S,
      output rsp_valid, rsp_id, rsp_o, rsp_flags, rsp_err
   );

   modport master (
      output req0_valid, req0_A, req0_B, req0_S,
      output req1_valid, req1_A, req1_B, req1_S,
      output alu_o, alu_zero, alu_negative, alu_carry, alu_overflow, alu_parity,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  alu_A, alu_B, alu_S,
      input  rsp_valid, rsp_id, rsp_o, rsp_flags, rsp_err
   );

endinterface

// File: rtl/alu_req_scheduler_rr_arbiter2.sv
// Two-input round-robin arbiter: a lone requester always wins, a tie goes to
// the requester that was not granted last.
module alu_req_scheduler_rr_arbiter2 (
   input  logic valid0,
   input  logic valid1,
   input  logic last,
   output logic grant0,
   output logic grant1
);

   assign grant0 = valid0 && (!valid1 || last);
   assign grant1 = valid1 && (!valid0 || !last);

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one external combinational ALU between two requesters: round-robin
// accept, hold operands for EXEC_CYCLES, register result/flags, return on rsp.
module alu_req_scheduler
   import alu_req_scheduler_pkg::*;
#(
   parameter int EXEC_CYCLES = 1,
   parameter int NUM_OPS     = 13
) (
   input logic             clk,
   input logic             rst,
   alu_req_scheduler_if.slave bus
);

   localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

   state_t      state;
   logic        rr_last;
   logic [3:0]  cnt;
   logic        grant0;
   logic        grant1;
   logic        accept;
   logic        trap;
   logic [7:0]  sel_A;
   logic [7:0]  sel_B;
   logic [3:0]  sel_S;
   logic [7:0]  alu_A_q;
   logic [7:0]  alu_B_q;
   logic [3:0]  alu_S_q;
   logic        rsp_valid_q;
   logic        rsp_id_q;
   logic [15:0] rsp_o_q;
   logic [4:0]  rsp_flags_q;
   logic        rsp_err_q;

   alu_req_scheduler_rr_arbiter2 u_rr_arbiter2 (
      .valid0 (bus.req0_valid),
      .valid1 (bus.req1_valid),
      .last   (rr_last),
      .grant0 (grant0),
      .grant1 (grant1)
   );

   // Ready is gated by rst so nothing is handshaken during the reset cycle itself.
   assign bus.req0_ready = (state == ST_IDLE) && !rst && grant0;
   assign bus.req1_ready = (state == ST_IDLE) && !rst && grant1;
   assign accept         = bus.req0_ready || bus.req1_ready;

   assign sel_A = grant1 ? bus.req1_A : bus.req0_A;
   assign sel_B = grant1 ? bus.req1_B : bus.req0_B;
   assign sel_S = grant1 ? bus.req1_S : bus.req0_S;
   assign trap  = is_trap(sel_B, sel_S, NUM_OPS);

   // NOTE: every register below is written with <= so all of them update from
   // the same pre-edge values; a blocking = here would create ordering races.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         rr_last     <= 1'b1;
         cnt         <= '0;
         alu_A_q     <= '0;
         alu_B_q     <= '0;
         alu_S_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_o_q     <= '0;
         rsp_flags_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  rr_last  <= grant1;
                  rsp_id_q <= grant1;
                  if (trap) begin
                     rsp_o_q     <= '0;
                     rsp_flags_q <= '0;
                     rsp_err_q   <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     state       <= ST_RESP;
                  end else begin
                     // The operand registers are the ALU input registers; they stay
                     // frozen until the next legal accept.
                     alu_A_q <= sel_A;
                     alu_B_q <= sel_B;
                     alu_S_q <= sel_S;
                     cnt     <= '0;
                     state   <= ST_EXEC;
                  end
               end
            end
            ST_EXEC: begin
               if (cnt == LAST_CNT) begin
                  rsp_o_q                  <= bus.alu_o;
                  rsp_flags_q[FLAG_ZERO]   <= bus.alu_zero;
                  rsp_flags_q[FLAG_NEG]    <= bus.alu_negative;
                  rsp_flags_q[FLAG_CARRY]  <= bus.alu_carry;
                  rsp_flags_q[FLAG_OVF]    <= bus.alu_overflow;
                  rsp_flags_q[FLAG_PARITY] <= bus.alu_parity;
                  rsp_err_q                <= 1'b0;
                  rsp_valid_q              <= 1'b1;
                  state                    <= ST_RESP;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.alu_A     = alu_A_q;
   assign bus.alu_B     = alu_B_q;
   assign bus.alu_S     = alu_S_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_o     = rsp_o_q;
   assign bus.rsp_flags = rsp_flags_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Randomized self-checking bench: models the ALU environment and predicts each
// response (winner, latency, result, trap) from the scheduling rules.
module tb_alu_req_scheduler;
   import alu_req_scheduler_pkg::*;

   localparam int EC      = 3;
   localparam int N_OPS   = 13;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fails  = 0;

   // Model state: who won last and what the ALU inputs currently hold.
   bit          m_last;
   logic [7:0]  m_alu_A;
   logic [7:0]  m_alu_B;
   logic [3:0]  m_alu_S;

   alu_req_scheduler_if bus ();

   alu_req_scheduler #(.EXEC_CYCLES(EC), .NUM_OPS(N_OPS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [20:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] s);
      logic [15:0] r;
      logic        c;
      logic        v;
      r = '0;
      c = 1'b0;
      v = 1'b0;
      case (s)
         OP_ADD: begin
            r = 16'(a) + 16'(b);
            c = r[8];
            v = (a[7] == b[7]) && (r[7] != a[7]);
         end
         OP_SUB: begin
            r = 16'(a) - 16'(b);
            c = a < b;
            v = (a[7] != b[7]) && (r[7] != a[7]);
         end
         OP_MUL:  r = 16'(a) * 16'(b);
         OP_AND:  r = 16'(a & b);
         OP_OR:   r = 16'(a | b);
         OP_XOR:  r = 16'(a ^ b);
         OP_MOD:  r = (b == 8'd0) ? 16'd0 : 16'(a % b);
         OP_SHL:  r = 16'(a) << b[3:0];
         OP_SHR:  r = 16'(a >> b[3:0]);
         OP_DIV:  r = (b == 8'd0) ? 16'd0 : 16'(a / b);
         OP_EQ:   r = 16'(a == b);
         OP_LT:   r = 16'(a < b);
         OP_GT:   r = 16'(a > b);
         default: r = '0;
      endcase
      return {r, r == 16'd0, r[15], c, v, ^r};
   endfunction

   assign {bus.alu_o, bus.alu_zero, bus.alu_negative, bus.alu_carry,
           bus.alu_overflow, bus.alu_parity} = alu_model(bus.alu_A, bus.alu_B, bus.alu_S);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One full transaction from offer to response retirement, all driving at negedge.
   task automatic run_op(input bit v0, input bit v1,
                         input logic [7:0] a0, input logic [7:0] b0, input logic [3:0] s0,
                         input logic [7:0] a1, input logic [7:0] b1, input logic [3:0] s1,
                         input int hold);
      bit          w;
      bit          trap;
      bit          seen;
      int          lat;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [3:0]  s;
      logic [20:0] exp;
      w    = (v0 && v1) ? !m_last : v1;
      a    = w ? a1 : a0;
      b    = w ? b1 : b0;
      s    = w ? s1 : s0;
      trap = ((s == 4'd6 || s == 4'd9) && b == 8'd0) || (int'(s) >= N_OPS);
      exp  = trap ? 21'd0 : alu_model(a, b, s);

      @(negedge clk);
      bus.req0_valid = v0; bus.req0_A = a0; bus.req0_B = b0; bus.req0_S = s0;
      bus.req1_valid = v1; bus.req1_A = a1; bus.req1_B = b1; bus.req1_S = s1;
      #1;
      check("req0_ready", bus.req0_ready, 32'(!w));
      check("req1_ready", bus.req1_ready, 32'(w));

      @(negedge clk);
      bus.req0_valid = 1'b0; bus.req0_A = 8'($urandom); bus.req0_S = 4'($urandom);
      bus.req1_valid = 1'b0; bus.req1_A = 8'($urandom); bus.req1_S = 4'($urandom);
      m_last = w;
      lat  = 1;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (bus.rsp_valid) begin
            seen = 1'b1;
         end else begin
            check("exec_alu_A", bus.alu_A, a);
            check("exec_alu_B", bus.alu_B, b);
            check("exec_alu_S", bus.alu_S, s);
            lat++;
            @(negedge clk);
         end
      end
      check("rsp_seen", seen, 1);
      check("latency", lat, trap ? 1 : 1 + EC);
      if (!trap) begin
         m_alu_A = a; m_alu_B = b; m_alu_S = s;
      end
      check("alu_A", bus.alu_A, m_alu_A);
      check("alu_B", bus.alu_B, m_alu_B);
      check("alu_S", bus.alu_S, m_alu_S);
      check("rsp_id", bus.rsp_id, 32'(w));
      check("rsp_err", bus.rsp_err, 32'(trap));
      check("rsp_o", bus.rsp_o, exp[20:5]);
      check("rsp_flags", bus.rsp_flags, exp[4:0]);

      for (int i = 0; i < hold; i++) begin
         bus.req0_valid = 1'b1;
         bus.req1_valid = 1'b1;
         @(negedge clk);
         check("hold_valid", bus.rsp_valid, 1);
         check("hold_rsp_o", bus.rsp_o, exp[20:5]);
         check("hold_ready0", bus.req0_ready, 0);
         check("hold_ready1", bus.req1_ready, 0);
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.rsp_ready  = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check("rsp_retired", bus.rsp_valid, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
      check({tag, "_rsp_o"}, bus.rsp_o, 0);
      check({tag, "_rsp_flags"}, bus.rsp_flags, 0);
      check({tag, "_rsp_err"}, bus.rsp_err, 0);
      check({tag, "_rsp_id"}, bus.rsp_id, 0);
      check({tag, "_alu"}, {bus.alu_A, bus.alu_B, bus.alu_S}, 0);
      check({tag, "_ready0"}, bus.req0_ready, 0);
      check({tag, "_ready1"}, bus.req1_ready, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit v0;
      bit v1;
      int pick;
      rst = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_A = 8'd1; bus.req0_B = 8'd1; bus.req0_S = 4'd0;
      bus.req1_valid = 1'b1; bus.req1_A = 8'd1; bus.req1_B = 8'd1; bus.req1_S = 4'd0;
      bus.rsp_ready  = 1'b0;
      m_last = 1'b1; m_alu_A = '0; m_alu_B = '0; m_alu_S = '0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;

      // Ties after reset: round-robin order 0,1,0.
      run_op(1, 1, 8'd3, 8'd4, OP_ADD, 8'd9, 8'd2, OP_SUB, 0);
      run_op(1, 1, 8'd3, 8'd4, OP_XOR, 8'd9, 8'd2, OP_SUB, 0);
      run_op(1, 1, 8'd5, 8'd4, OP_OR,  8'd9, 8'd2, OP_AND, 0);

      // Carry-out add, then the three trap kinds from requester 1.
      run_op(1, 0, 8'd200, 8'd100, OP_ADD, 8'd0, 8'd0, OP_ADD, 0);
      run_op(0, 1, 8'd0, 8'd0, OP_ADD, 8'd7, 8'd0, OP_DIV, 0);
      run_op(0, 1, 8'd0, 8'd0, OP_ADD, 8'd7, 8'd0, OP_MOD, 1);
      run_op(0, 1, 8'd0, 8'd0, OP_ADD, 8'd7, 8'd3, 4'd13, 0);

      // Back-pressure on the response, then the widest multiply.
      run_op(1, 0, 8'd12, 8'd12, OP_EQ, 8'd0, 8'd0, OP_ADD, 5);
      run_op(1, 0, 8'd255, 8'd255, OP_MUL, 8'd0, 8'd0, OP_ADD, 0);
      run_op(1, 0, 8'd4, 8'd9, OP_SUB, 8'd0, 8'd0, OP_ADD, 0);

      for (int n = 0; n < 30; n++) begin
         pick = $urandom_range(2, 0);
         v0 = (pick != 1);
         v1 = (pick != 0);
         run_op(v0, v1,
                8'($urandom), ($urandom_range(3, 0) == 0) ? 8'd0 : 8'($urandom), 4'($urandom),
                8'($urandom), ($urandom_range(3, 0) == 0) ? 8'd0 : 8'($urandom), 4'($urandom),
                $urandom_range(3, 0));
      end

      // Reset while executing: the op vanishes and arbitration state restarts.
      @(negedge clk);
      bus.req1_valid = 1'b1; bus.req1_A = 8'd50; bus.req1_B = 8'd3; bus.req1_S = OP_MUL;
      @(negedge clk);
      bus.req1_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_last = 1'b1; m_alu_A = '0; m_alu_B = '0; m_alu_S = '0;
      check_reset_outputs("midreset");
      for (int i = 0; i < EC + 3; i++) begin
         @(negedge clk);
         check("midreset_no_rsp", bus.rsp_valid, 0);
      end
      run_op(1, 1, 8'd11, 8'd6, OP_SUB, 8'd7, 8'd8, OP_ADD, 0);
      run_op(1, 1, 8'd11, 8'd6, OP_GT,  8'd7, 8'd8, OP_LT, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
